fdc_sd_arbiter: RTL and testbench
=================================

Name: fdc_sd_arbiter

Overview:
- Sits directly downstream of the four-drive floppy controller.
- Merges its four per-drive SD block request channels (lba, rd, wr, ack, buff_din) into the single block-request port of the HPS sd interface.
- Arbitrates round-robin, routes the ack back to the granted drive, and muxes that drive's buffer read data.
- One transfer is in flight at a time; the transfer size is always one block.

Parameters:
- NDRV, 4: number of drive channels (2..4 supported).
- TIMEOUT_CYC, 24'd10_000_000: watchdog limit in CLK cycles. Used only when the optional feature is compiled in.

Ports:
- CLK  in  1  system clock; all logic is on the negedge, matching the controller.
- RESET  in  1  asynchronous, active-high reset.
- drv_lba  in  32 x NDRV  per-drive block address.
- drv_rd  in  NDRV  per-drive read request; level, held until ack.
- drv_wr  in  NDRV  per-drive write request; level, held until ack.
- drv_ack  out  NDRV  per-drive ack; only the granted bit can be 1.
- drv_buff_din  in  8 x NDRV  per-drive buffer read data (the write path to SD).
- hps_lba  out  32  granted lba.
- hps_rd  out  1  read request to HPS.
- hps_wr  out  1  write request to HPS.
- hps_ack  in  1  HPS ack.
- hps_buff_din  out  8  granted drive's buffer data.
- busy  out  1  high in any state other than IDLE.
- grant  out  2  index of the current or last granted drive.

Behaviour:
- Reset values: hps_rd=0, hps_wr=0, hps_lba=0, drv_ack=0, busy=0, grant=0, rr_ptr=0, state=IDLE.
- State machine: IDLE -> REQ -> XFER -> DONE -> IDLE.
- IDLE:
  - Scan requests (drv_rd|drv_wr) starting at rr_ptr, wrapping modulo NDRV.
  - On the first hit: latch grant, latch hps_lba=drv_lba[grant], latch op (rd has priority if both rd and wr are set), go to REQ.
  - No request: stay in IDLE, outputs quiet.
- REQ:
  - Assert hps_rd or hps_wr, registered one cycle after the grant latch, so request latency is 2 CLK from drv_rd/wr.
  - Wait for hps_ack=1, then deassert hps_rd/hps_wr and go to XFER.
  - If the granted drive drops its request before ack (drive reset): deassert, go to IDLE, do not rotate.
- XFER:
  - drv_ack[grant]=hps_ack, combinational.
  - The HPS streams bytes: the controller sees sd_buff_addr/dout/wr broadcast directly, and hps_buff_din=drv_buff_din[grant].
  - When hps_ack falls, go to DONE.
- DONE:
  - One cycle with drv_ack=0; rr_ptr=(grant+1)%NDRV; go to IDLE.
  - The released drive has deasserted its request by now. If it has not, it is re-arbitrated normally.
- Muxing rules:
  - hps_buff_din muxes by the registered grant in all states, so data is stable before ack.
  - drv_ack bits are forced to 0 outside REQ/XFER.
- Error and boundary cases:
  - hps_ack high while in IDLE: ignored, no drv_ack generated.
  - A new request on a non-granted drive during a transfer is held and serviced in a later IDLE. No request is ever lost, because requests are levels.
  - Fairness: with all NDRV requesting continuously, grants cycle 0,1,2,3,0.
  - RESET mid-transfer: everything returns to reset values immediately; the HPS sees hps_rd/wr drop.
  - Indices >= NDRV are never granted.

Optional Feature:
- Macro: FDC_SD_TIMEOUT_EN.
- When defined:
  - A 24-bit counter clears on entry to REQ and increments in REQ/XFER.
  - On reaching TIMEOUT_CYC: force hps_rd/wr=0 and drv_ack=0, pulse output timeout (1 cycle), go to DONE with normal rotation.
  - A sticky bit timeout_seen is cleared only by RESET.
- When undefined:
  - No counter, no timeout/timeout_seen ports.
  - REQ/XFER wait indefinitely.

Decomposition:
- Package fdc_sd_pkg holds:
  - typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} arb_state_t;
  - localparam BLK_BYTES=512;
  - typedef logic [31:0] lba_t.
- One sub-module, fdc_rr_pick: combinational round-robin priority encoder; inputs req[NDRV] and ptr, outputs hit and idx.

Test Plan:
- Single read: drv_rd[1]=1, lba=0x0000_0123 -> after 2 CLK hps_rd=1, hps_lba=0x123; hps_ack=1 -> hps_rd=0 and drv_ack=4'b0010; hps_ack=0 -> drv_ack=0, grant=1, rr_ptr=2.
- Contention: drv_wr[0] and drv_rd[3] set together with rr_ptr=2 -> drive 3 served first, then drive 0; drv_ack never has two bits set.
- Write data path: grant=2 and drv_buff_din[2]=0xA5 during XFER -> hps_buff_din=0xA5; drv_buff_din[0]=0x5A is never seen.
- Abort: drv_rd[0] drops in REQ before ack -> hps_rd=0 next cycle, state IDLE, rr_ptr unchanged.
- Reset in XFER: RESET pulse -> hps_rd/wr=0, drv_ack=0, busy=0 asynchronously.
- With FDC_SD_TIMEOUT_EN and TIMEOUT_CYC=100: request with no hps_ack -> timeout pulses at cycle 100, timeout_seen=1, the next requester is granted.

Source files
------------

// File: rtl/fdc_sd_pkg.sv
// Shared types for the floppy-controller to HPS SD block-request arbiter.
package fdc_sd_pkg;

  typedef enum logic [1:0] {IDLE, REQ, XFER, DONE} arb_state_t;

  localparam int BLK_BYTES = 512;

  typedef logic [31:0] lba_t;

endpackage

// File: rtl/fdc_sd_arbiter_if.sv
// Per-drive request channels plus the single HPS block-request port.
interface fdc_sd_arbiter_if #(
  parameter int NDRV = 4
);
  import fdc_sd_pkg::*;

  lba_t [NDRV-1:0]       drv_lba;
  logic [NDRV-1:0]       drv_rd;
  logic [NDRV-1:0]       drv_wr;
  logic [NDRV-1:0]       drv_ack;
  logic [NDRV-1:0][7:0]  drv_buff_din;
  lba_t                  hps_lba;
  logic                  hps_rd;
  logic                  hps_wr;
  logic                  hps_ack;
  logic [7:0]            hps_buff_din;
  logic                  busy;
  logic [1:0]            grant;

  // master is the arbiter itself; slave is the controller/HPS environment
  modport master (
    input  drv_lba, drv_rd, drv_wr, drv_buff_din, hps_ack,
    output drv_ack, hps_lba, hps_rd, hps_wr, hps_buff_din, busy, grant
  );

  modport slave (
    output drv_lba, drv_rd, drv_wr, drv_buff_din, hps_ack,
    input  drv_ack, hps_lba, hps_rd, hps_wr, hps_buff_din, busy, grant
  );

endinterface

// File: rtl/fdc_rr_pick.sv
// Combinational round-robin priority encoder: first set request at or after ptr.
module fdc_rr_pick #(
  parameter int NDRV = 4
) (
  input  logic [NDRV-1:0] req_i,
  input  logic [1:0]      ptr_i,
  output logic            hit_o,
  output logic [1:0]      idx_o
);

  // Walk from the farthest offset back to ptr so the nearest request wins.
  always_comb begin
    hit_o = 1'b0;
    idx_o = 2'd0;
    for (int i = NDRV - 1; i >= 0; i--) begin
      if (req_i[(int'(ptr_i) + i) % NDRV]) begin
        hit_o = 1'b1;
        idx_o = 2'((int'(ptr_i) + i) % NDRV);
      end
    end
  end

endmodule

// File: rtl/fdc_sd_arbiter.sv
// Round-robin merge of NDRV floppy SD block channels onto one HPS port, negedge clocked.
// Optional watchdog compiled in with FDC_SD_TIMEOUT_EN.
module fdc_sd_arbiter
  import fdc_sd_pkg::*;
#(
  parameter int          NDRV        = 4,
  parameter logic [23:0] TIMEOUT_CYC = 24'd10_000_000
) (
  input  logic             CLK,
  input  logic             RESET,
  fdc_sd_arbiter_if.master bus
`ifdef FDC_SD_TIMEOUT_EN
  ,
  output logic             timeout,
  output logic             timeout_seen
`endif
);

  arb_state_t state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  lba_t       lba_q, lba_d;
  logic       op_rd_q, op_rd_d;
  logic       hps_rd_q, hps_rd_d;
  logic       hps_wr_q, hps_wr_d;

  logic       pick_hit;
  logic [1:0] pick_idx;
  logic       gnt_req;
  logic       to_hit;
  logic       unused_cfg;

  assign unused_cfg = ^{TIMEOUT_CYC, 10'(BLK_BYTES)};

  fdc_rr_pick #(.NDRV(NDRV)) u_pick (
    .req_i (bus.drv_rd | bus.drv_wr),
    .ptr_i (rr_ptr_q),
    .hit_o (pick_hit),
    .idx_o (pick_idx)
  );

  assign gnt_req = bus.drv_rd[grant_q] | bus.drv_wr[grant_q];

`ifdef FDC_SD_TIMEOUT_EN
  logic [23:0] cnt_q, cnt_d;
  logic        timeout_q, seen_q;

  assign to_hit = ((state_q == REQ) || (state_q == XFER)) &&
                  (cnt_q >= TIMEOUT_CYC - 24'd1);

  // Counter restarts on every grant so each transfer gets the full window.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && pick_hit)
      cnt_d = 24'd0;
    else if (state_q == REQ || state_q == XFER)
      cnt_d = cnt_q + 24'd1;
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q     <= 24'd0;
      timeout_q <= 1'b0;
      seen_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= to_hit;
      seen_q    <= seen_q | to_hit;
    end
  end

  assign timeout      = timeout_q;
  assign timeout_seen = seen_q;
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    lba_d    = lba_q;
    op_rd_d  = op_rd_q;
    hps_rd_d = 1'b0;
    hps_wr_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_hit) begin
          grant_d = pick_idx;
          lba_d   = bus.drv_lba[pick_idx];
          op_rd_d = bus.drv_rd[pick_idx];
          state_d = REQ;
        end
      end
      // A drive dropping its request before ack is a drive reset: no rotation.
      REQ: begin
        if (to_hit)
          state_d = DONE;
        else if (!gnt_req)
          state_d = IDLE;
        else if (bus.hps_ack)
          state_d = XFER;
        else begin
          hps_rd_d = op_rd_q;
          hps_wr_d = ~op_rd_q;
        end
      end
      XFER: begin
        if (to_hit || !bus.hps_ack)
          state_d = DONE;
      end
      DONE: begin
        rr_ptr_d = (int'(grant_q) == NDRV - 1) ? 2'd0 : grant_q + 2'd1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= IDLE;
      grant_q  <= 2'd0;
      rr_ptr_q <= 2'd0;
      lba_q    <= '0;
      op_rd_q  <= 1'b0;
      hps_rd_q <= 1'b0;
      hps_wr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      lba_q    <= lba_d;
      op_rd_q  <= op_rd_d;
      hps_rd_q <= hps_rd_d;
      hps_wr_q <= hps_wr_d;
    end
  end

  // Ack is routed straight through so the drive sees HPS timing unchanged.
  always_comb begin
    bus.drv_ack = '0;
    if ((state_q == REQ || state_q == XFER) && !to_hit)
      bus.drv_ack[grant_q] = bus.hps_ack;
  end

  assign bus.hps_rd       = hps_rd_q;
  assign bus.hps_wr       = hps_wr_q;
  assign bus.hps_lba      = lba_q;
  assign bus.hps_buff_din = bus.drv_buff_din[grant_q];
  assign bus.busy         = (state_q != IDLE);
  assign bus.grant        = grant_q;

endmodule

// File: tb/tb_fdc_sd_arbiter.sv
// Directed, scoreboard-checked bench for fdc_sd_arbiter (4 drives).
module tb_fdc_sd_arbiter;
  import fdc_sd_pkg::*;

  localparam int NDRV = 4;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  fdc_sd_arbiter_if #(.NDRV(NDRV)) bus ();

`ifdef FDC_SD_TIMEOUT_EN
  logic timeout;
  logic timeoutSeen;
`endif

  fdc_sd_arbiter #(.NDRV(NDRV)) dut (
    .CLK   (clk),
    .RESET (reset),
    .bus   (bus)
`ifdef FDC_SD_TIMEOUT_EN
    ,
    .timeout      (timeout),
    .timeout_seen (timeoutSeen)
`endif
  );

  typedef struct {
    logic [1:0] grant;
    lba_t       lba;
    logic       isRd;
    logic [7:0] buff;
  } expT;

  expT        expQ[$];
  expT        cur;
  int         checks = 0;
  int         passes = 0;
  lba_t       lbaTab[NDRV];
  logic [7:0] buffTab[NDRV];
  logic       prevReq = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input int drv, input logic rd, input logic wr);
    bus.drv_rd[drv] = rd;
    bus.drv_wr[drv] = wr;
  endtask

  task automatic pushExp(input int drv, input logic isRd);
    expT e;
    e.grant = 2'(drv);
    e.lba   = lbaTab[drv];
    e.isRd  = isRd;
    e.buff  = buffTab[drv];
    expQ.push_back(e);
  endtask

  task automatic waitReq();
    int n = 0;
    while (!(bus.hps_rd | bus.hps_wr) && n < 20) begin
      @(negedge clk); #2;
      n++;
    end
    checkOutput("reqWait", 32'(bus.hps_rd | bus.hps_wr), 32'd1);
  endtask

  // HPS side: ack one block; the granted drive drops its request once it sees ack.
  task automatic serveXfer(input logic [3:0] relMask, input int nBeats);
    waitReq();
    @(posedge clk);
    bus.hps_ack = 1'b1;
    @(posedge clk);
    bus.drv_rd = bus.drv_rd & ~relMask;
    bus.drv_wr = bus.drv_wr & ~relMask;
    repeat (nBeats) @(posedge clk);
    bus.hps_ack = 1'b0;
    repeat (2) @(negedge clk);
    #2;
  endtask

  // Monitor: every new HPS request must match the queue head; ack cycles check data path.
  initial begin
    cur = '{grant: 2'd0, lba: '0, isRd: 1'b0, buff: 8'd0};
    forever begin
      @(negedge clk); #2;
      if ((bus.hps_rd | bus.hps_wr) && !prevReq) begin
        if (expQ.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpectedReq: got grant %0d, want no request", bus.grant);
        end else begin
          cur = expQ.pop_front();
          checkOutput("reqGrant", 32'(bus.grant), 32'(cur.grant));
          checkOutput("reqLba", bus.hps_lba, cur.lba);
          checkOutput("reqRd", 32'(bus.hps_rd), 32'(cur.isRd));
          checkOutput("reqWr", 32'(bus.hps_wr), 32'(!cur.isRd));
        end
      end
      if (bus.drv_ack != '0) begin
        checkOutput("ackOneHot", 32'(bus.drv_ack), 32'(1) << cur.grant);
        checkOutput("buffDin", 32'(bus.hps_buff_din), 32'(cur.buff));
      end
      prevReq = bus.hps_rd | bus.hps_wr;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation got no end, want finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    lbaTab[0] = 32'hA000_0000; buffTab[0] = 8'h5A;
    lbaTab[1] = 32'h0000_0123; buffTab[1] = 8'h11;
    lbaTab[2] = 32'h0BAD_F00D; buffTab[2] = 8'hA5;
    lbaTab[3] = 32'h3333_3333; buffTab[3] = 8'h33;
    for (int i = 0; i < NDRV; i++) begin
      bus.drv_lba[i]      = lbaTab[i];
      bus.drv_buff_din[i] = buffTab[i];
    end
    bus.drv_rd  = '0;
    bus.drv_wr  = '0;
    bus.hps_ack = 1'b0;
    reset       = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstHpsRd", 32'(bus.hps_rd), 32'd0);
    checkOutput("rstHpsWr", 32'(bus.hps_wr), 32'd0);
    checkOutput("rstLba", bus.hps_lba, 32'd0);
    checkOutput("rstAck", 32'(bus.drv_ack), 32'd0);
    checkOutput("rstBusy", 32'(bus.busy), 32'd0);
    checkOutput("rstGrant", 32'(bus.grant), 32'd0);
    @(posedge clk);
    reset = 1'b0;

    // Stray HPS ack while idle must not reach any drive.
    bus.hps_ack = 1'b1;
    repeat (3) @(negedge clk);
    #2;
    checkOutput("idleAck", 32'(bus.drv_ack), 32'd0);
    checkOutput("idleBusy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    bus.hps_ack = 1'b0;

    // Single read on drive 1 with explicit latency checks.
    @(posedge clk);
    applyStimulus(1, 1'b1, 1'b0);
    pushExp(1, 1'b1);
    @(negedge clk); #2;
    checkOutput("rdLat1", 32'(bus.hps_rd), 32'd0);
    checkOutput("rdBusy", 32'(bus.busy), 32'd1);
    @(negedge clk); #2;
    checkOutput("rdLat2", 32'(bus.hps_rd), 32'd1);
    checkOutput("rdLba", bus.hps_lba, 32'h0000_0123);
    @(posedge clk);
    bus.hps_ack = 1'b1;
    @(negedge clk); #2;
    checkOutput("rdDrop", 32'(bus.hps_rd), 32'd0);
    checkOutput("rdAck", 32'(bus.drv_ack), 32'b0010);
    @(posedge clk);
    applyStimulus(1, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    bus.hps_ack = 1'b0;
    @(negedge clk); #2;
    checkOutput("doneAck", 32'(bus.drv_ack), 32'd0);
    checkOutput("doneBusy", 32'(bus.busy), 32'd1);
    @(negedge clk); #2;
    checkOutput("idleAfterRd", 32'(bus.busy), 32'd0);
    checkOutput("rdGrant", 32'(bus.grant), 32'd1);

    // Contention with rr_ptr=2: drive 3 before drive 0.
    @(posedge clk);
    applyStimulus(0, 1'b0, 1'b1);
    applyStimulus(3, 1'b1, 1'b0);
    pushExp(3, 1'b1);
    pushExp(0, 1'b0);
    serveXfer(4'b1000, 2);
    serveXfer(4'b0001, 2);
    checkOutput("contGrant", 32'(bus.grant), 32'd0);

    // Write from drive 2 while drive 0 presents different buffer data.
    @(posedge clk);
    applyStimulus(2, 1'b0, 1'b1);
    pushExp(2, 1'b0);
    serveXfer(4'b0100, 4);
    checkOutput("wrGrant", 32'(bus.grant), 32'd2);
    checkOutput("wrBuff", 32'(bus.hps_buff_din), 32'hA5);

    // Abort: drive 0 drops its read in REQ; pointer must stay at 3.
    @(posedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    pushExp(0, 1'b1);
    waitReq();
    @(posedge clk);
    applyStimulus(0, 1'b0, 1'b0);
    @(negedge clk); #2;
    checkOutput("abortRd", 32'(bus.hps_rd), 32'd0);
    checkOutput("abortBusy", 32'(bus.busy), 32'd0);
    @(posedge clk);
    applyStimulus(0, 1'b1, 1'b0);
    applyStimulus(2, 1'b1, 1'b0);
    pushExp(0, 1'b1);
    pushExp(2, 1'b1);
    serveXfer(4'b0001, 2);
    serveXfer(4'b0100, 2);

    // Reset during XFER clears everything without a clock edge.
    @(posedge clk);
    applyStimulus(1, 1'b1, 1'b0);
    pushExp(1, 1'b1);
    waitReq();
    @(posedge clk);
    bus.hps_ack = 1'b1;
    @(negedge clk); #2;
    checkOutput("xferAck", 32'(bus.drv_ack), 32'b0010);
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("arstRd", 32'(bus.hps_rd | bus.hps_wr), 32'd0);
    checkOutput("arstAck", 32'(bus.drv_ack), 32'd0);
    checkOutput("arstBusy", 32'(bus.busy), 32'd0);
    checkOutput("arstGrant", 32'(bus.grant), 32'd0);
    bus.hps_ack = 1'b0;
    applyStimulus(1, 1'b0, 1'b0);
    @(posedge clk);
    reset = 1'b0;

    // Fairness: all four requesting continuously, grants 0,1,2,3,0.
    @(posedge clk);
    bus.drv_rd = 4'b1111;
    pushExp(0, 1'b1);
    pushExp(1, 1'b1);
    pushExp(2, 1'b1);
    pushExp(3, 1'b1);
    pushExp(0, 1'b1);
    repeat (4) serveXfer(4'b0000, 2);
    serveXfer(4'b1111, 2);
    repeat (3) @(negedge clk);
    #2;
    checkOutput("fairBusy", 32'(bus.busy), 32'd0);
    checkOutput("fairGrant", 32'(bus.grant), 32'd0);
    checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
